// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg: opcode encodings, datapath width and the logical-right      |
// | shifter helper shared by the ALU shift pipeline.                     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OP_SRL  = 2'b00,
    OP_SLL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  function automatic logic [DATA_W-1:0] lsr(input logic [DATA_W-1:0] a,
                                            input logic [4:0]        n);
    return a >> n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_shift_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_shift_pipe_if: operand-issue and result handshake bundle.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface alu_shift_pipe_if
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x;
  logic [DATA_W-1:0] y;
  op_e               op;
  logic [TAG_W-1:0]  tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] z;
  logic [TAG_W-1:0]  out_tag;
  logic              zero;

  modport master (
    output in_valid, x, y, op, tag, out_ready,
    input  in_ready, out_valid, z, out_tag, zero
  );

  modport slave (
    input  in_valid, x, y, op, tag, out_ready,
    output in_ready, out_valid, z, out_tag, zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_shift_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_shift_core: combinational SRL/SLL/SRA/PASS with amount clamping. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_shift_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  op_e               op,
  output logic [DATA_W-1:0] z
);

  logic              w_big;
  logic [4:0]        w_amt;
  logic [DATA_W-1:0] w_srl;
  logic [DATA_W-1:0] w_sll;
  logic [DATA_W-1:0] w_sra;

  // Any set bit above bit 4 means the amount is 32 or more, Y[31] included.
  assign w_big = |y[DATA_W-1:5];
  assign w_amt = y[4:0];

  always_comb begin
    w_srl = lsr(x, w_amt);
    w_sll = x << w_amt;
    w_sra = $unsigned($signed(x) >>> w_amt);
    if (w_big) begin
      w_srl = '0;
      w_sll = '0;
      w_sra = {DATA_W{x[DATA_W-1]}};
    end
  end

  always_comb begin
    z = x;
    case (op)
      OP_SRL:  z = w_srl;
      OP_SLL:  z = w_sll;
      OP_SRA:  z = w_sra;
      OP_PASS: z = x;
      default: z = x;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_shift_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_shift_pipe: two-stage valid/ready pipeline around the shift core |
// | with flush and a completed-operation counter.                        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_shift_pipe
  import alu_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_shift_pipe_if.slave     bus,
  output logic                busy,
  output logic [CNT_W-1:0]    op_count
);

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_x;
  logic [DATA_W-1:0] r_s1_y;
  op_e               r_s1_op;
  logic [TAG_W-1:0]  r_s1_tag;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_z;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_zero;
  logic [CNT_W-1:0]  r_count;

  logic              w_adv1;
  logic              w_adv2;
  logic              w_accept;
  logic              w_consume;
  logic [DATA_W-1:0] w_z;

  assign w_adv2    = !r_s2_valid || bus.out_ready;
  assign w_adv1    = !r_s1_valid || w_adv2;
  assign w_accept  = bus.in_valid && bus.in_ready;
  assign w_consume = r_s2_valid && bus.out_ready;

  assign bus.in_ready  = w_adv1 && !flush;
  assign bus.out_valid = r_s2_valid;
  assign bus.z         = r_z;
  assign bus.out_tag   = r_out_tag;
  assign bus.zero      = r_zero;
  assign busy          = r_s1_valid || r_s2_valid;
  assign op_count      = r_count;

  alu_shift_core u_core (
    .x  (r_s1_x),
    .y  (r_s1_y),
    .op (r_s1_op),
    .z  (w_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_op    <= OP_SRL;
      r_s1_tag   <= '0;
      r_s2_valid <= 1'b0;
      r_z        <= '0;
      r_out_tag  <= '0;
      r_zero     <= 1'b0;
      r_count    <= '0;
    end else begin
      // A result leaving during a flush was delivered, so it still counts.
      if (w_consume) begin
        r_count <= r_count + 1'b1;
      end
      if (flush) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
      end else begin
        if (w_adv2) begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_z       <= w_z;
            r_out_tag <= r_s1_tag;
            r_zero    <= (w_z == '0);
          end
        end
        if (w_adv1) begin
          r_s1_valid <= bus.in_valid;
        end
        if (w_accept) begin
          r_s1_x   <= bus.x;
          r_s1_y   <= bus.y;
          r_s1_op  <= bus.op;
          r_s1_tag <= bus.tag;
        end
      end
    end
  end

endmodule
`default_nettype wire
